button_switch_debouncer: RTL and testbench



---
 rtl/debounce_pkg.sv | 17 +
 rtl/button_switch_debouncer_if.sv | 23 ++
 rtl/debounce_bit.sv | 59 +++++
 rtl/button_switch_debouncer.sv | 74 +++++++
 tb/tb_button_switch_debouncer.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared constants, counter sizing helper and channel state encoding for the
// button/switch debouncer.
package debounce_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_SYNC_STAGES     = 2;

    typedef enum logic {
        IDLE,
        COUNTING
    } deb_state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/button_switch_debouncer_if.sv
// Raw board inputs and conditioned PIO-facing outputs of the debouncer.
// The master side drives raw pins; the slave side is the debouncer itself.
interface button_switch_debouncer_if #(
    parameter int NUM_BUTTONS  = 2,
    parameter int NUM_SWITCHES = 4
);
    logic [NUM_BUTTONS-1:0]  key_raw;
    logic [NUM_SWITCHES-1:0] sw_raw;
    logic [NUM_BUTTONS-1:0]  pushbuttons_export;
    logic [NUM_SWITCHES-1:0] dip_switches_export;
    logic                    inputs_settled;
    logic [NUM_BUTTONS-1:0]  key_press_pulse;

    modport master (
        output key_raw, sw_raw,
        input  pushbuttons_export, dip_switches_export, inputs_settled, key_press_pulse
    );

    modport slave (
        input  key_raw, sw_raw,
        output pushbuttons_export, dip_switches_export, inputs_settled, key_press_pulse
    );
endinterface

// File: rtl/debounce_bit.sv
// One debounced channel: synchroniser chain, stable-time counter and the
// accepted level. The channel state is implied by comparing synced vs accepted.
module debounce_bit
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic raw_in,
    output logic level_out,
    output logic busy
);
    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  TERMINAL = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   q, q_next;
    logic [CW-1:0]          cnt, cnt_next;
    deb_state_t             state;

    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
            cnt    <= '0;
            q      <= RESET_LEVEL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
            cnt    <= cnt_next;
            q      <= q_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state    = (s != q) ? COUNTING : IDLE;
        cnt_next = '0;
        q_next   = q;
        case (state)
            IDLE: ;
            COUNTING: begin
                // Terminal compare before increment keeps the counter from wrapping.
                if (cnt == TERMINAL) q_next = s;
                else                 cnt_next = cnt + 1'b1;
            end
            default: ;
        endcase
    end

    assign level_out = q;
    assign busy      = (state == COUNTING);

endmodule

// File: rtl/button_switch_debouncer.sv
// Debounces board pushbuttons and DIP switches for the nios_system PIOs.
// Optional macro DEBOUNCE_PRESS_PULSE_EN enables the one-cycle key press strobe.
module button_switch_debouncer
    import debounce_pkg::*;
#(
    parameter int NUM_BUTTONS     = 2,
    parameter int NUM_SWITCHES    = 4,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    button_switch_debouncer_if.slave  bus
);
    localparam int NUM_CH = NUM_BUTTONS + NUM_SWITCHES;

    logic [NUM_BUTTONS-1:0]  key_level;
    logic [NUM_SWITCHES-1:0] sw_level;
    logic [NUM_CH-1:0]       busy;
    logic                    settled_q;

    // Buttons are active-low on the board, so they rest at 1 (released).
    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_key
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_LEVEL    (1'b1)
        ) u_bit (
            .clk_clk      (clk_clk),
            .reset_reset_n(reset_reset_n),
            .raw_in       (bus.key_raw[i]),
            .level_out    (key_level[i]),
            .busy         (busy[i])
        );
    end

    for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_sw
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_LEVEL    (1'b0)
        ) u_bit (
            .clk_clk      (clk_clk),
            .reset_reset_n(reset_reset_n),
            .raw_in       (bus.sw_raw[i]),
            .level_out    (sw_level[i]),
            .busy         (busy[NUM_BUTTONS + i])
        );
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) settled_q <= 1'b1;
        else                settled_q <= ~|busy;
    end

`ifdef DEBOUNCE_PRESS_PULSE_EN
    logic [NUM_BUTTONS-1:0] key_level_d;

    // Previous level resets to released, so leaving reset never looks like a press.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) key_level_d <= '1;
        else                key_level_d <= key_level;
    end

    assign bus.key_press_pulse = key_level_d & ~key_level;
`else
    assign bus.key_press_pulse = '0;
`endif

    assign bus.pushbuttons_export  = key_level;
    assign bus.dip_switches_export = sw_level;
    assign bus.inputs_settled      = settled_q;

endmodule

// File: tb/tb_button_switch_debouncer.sv
// Directed bench for button_switch_debouncer with DEBOUNCE_CYCLES=8, SYNC_STAGES=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_button_switch_debouncer;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

`ifdef DEBOUNCE_PRESS_PULSE_EN
    localparam bit PULSE_EN = 1'b1;
`else
    localparam bit PULSE_EN = 1'b0;
`endif

    button_switch_debouncer_if #(.NUM_BUTTONS(2), .NUM_SWITCHES(4)) bus ();

    button_switch_debouncer #(
        .NUM_BUTTONS    (2),
        .NUM_SWITCHES   (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .bus          (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pass n rising edges, then stop at the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input logic [1:0] k, input logic [3:0] s);
        check({tag, "_key"}, 32'(bus.pushbuttons_export), 32'(k));
        check({tag, "_sw"},  32'(bus.dip_switches_export), 32'(s));
    endtask

    initial begin
        // 1. Reset with raw inputs opposite to the reset values
        rst_n       = 1'b0;
        bus.key_raw = 2'b00;
        bus.sw_raw  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_outs("rst", 2'b11, 4'b0000);
            check("rst_settled", 32'(bus.inputs_settled), 32'd1);
            check("rst_pulse", 32'(bus.key_press_pulse), 32'd0);
        end
        rst_n = 1'b1;
        step(9);
        check_outs("rel_edge8", 2'b11, 4'b0000);
        check("rel_settled_busy", 32'(bus.inputs_settled), 32'd0);
        step(1);
        check_outs("rel_edge9", 2'b00, 4'b1111);
        check("rel_pulse", 32'(bus.key_press_pulse), PULSE_EN ? 32'h3 : 32'h0);
        step(1);
        check("rel_pulse_once", 32'(bus.key_press_pulse), 32'd0);
        check("rel_settled", 32'(bus.inputs_settled), 32'd1);

        // Return to a released / all-off baseline through reset
        bus.key_raw = 2'b11;
        bus.sw_raw  = 4'b0000;
        rst_n       = 1'b0;
        step(1);
        check_outs("base_rst", 2'b11, 4'b0000);
        check("base_rst_pulse", 32'(bus.key_press_pulse), 32'd0);
        rst_n = 1'b1;
        step(2);
        check("base_settled", 32'(bus.inputs_settled), 32'd1);

        // 2. Bounce on key 0: 3-cycle segments 0,1,0,1,0,1,0 then hold 0
        for (int seg = 0; seg < 7; seg++) begin
            bus.key_raw = {1'b1, logic'(seg % 2)};
            step(3);
            check("bounce_hold", 32'(bus.pushbuttons_export), 32'h3);
        end
        step(6);
        check("bounce_edge8", 32'(bus.pushbuttons_export), 32'h3);
        step(1);
        check("bounce_edge9", 32'(bus.pushbuttons_export), 32'h2);
        check("press_pulse", 32'(bus.key_press_pulse), PULSE_EN ? 32'h1 : 32'h0);
        step(1);
        check("press_pulse_once", 32'(bus.key_press_pulse), 32'd0);
        bus.key_raw = 2'b11;
        step(10);
        check("release_key", 32'(bus.pushbuttons_export), 32'h3);
        check("release_no_pulse", 32'(bus.key_press_pulse), 32'd0);
        step(2);
        check("release_settled", 32'(bus.inputs_settled), 32'd1);

        // 3. Glitch of 7 cycles on switch 2
        bus.sw_raw = 4'b0100;
        step(5);
        check("glitch_settled_low", 32'(bus.inputs_settled), 32'd0);
        check("glitch_sw_mid", 32'(bus.dip_switches_export), 32'h0);
        step(2);
        bus.sw_raw = 4'b0000;
        step(12);
        check("glitch_sw_end", 32'(bus.dip_switches_export), 32'h0);
        check("glitch_settled_back", 32'(bus.inputs_settled), 32'd1);

        // 4. Two switches change together
        bus.sw_raw = 4'b1010;
        step(9);
        check("simul_edge8", 32'(bus.dip_switches_export), 32'h0);
        step(1);
        check("simul_edge9", 32'(bus.dip_switches_export), 32'hA);
        step(2);
        check("simul_settled", 32'(bus.inputs_settled), 32'd1);

        // 5. Key 1 pressed, reset lands at count 5
        bus.key_raw = 2'b01;
        step(7);
        check("midcnt_before_rst", 32'(bus.pushbuttons_export), 32'h3);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1);
            check_outs("midcnt_rst", 2'b11, 4'b0000);
            check("midcnt_rst_settled", 32'(bus.inputs_settled), 32'd1);
            check("midcnt_rst_pulse", 32'(bus.key_press_pulse), 32'd0);
        end
        rst_n = 1'b1;
        step(9);
        check_outs("midcnt_edge8", 2'b11, 4'b0000);
        step(1);
        check_outs("midcnt_edge9", 2'b01, 4'b1010);
        check("midcnt_pulse", 32'(bus.key_press_pulse), PULSE_EN ? 32'h2 : 32'h0);
        step(1);
        check("midcnt_pulse_once", 32'(bus.key_press_pulse), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
